// File: rtl/obi_sbr_mem.sv
// OBI subordinate backed by a small word-addressed memory.
// Optional grant wait states and an in-order response FIFO decouple the A and R channels.
module obi_sbr_mem #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 16,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int unsigned GNT_WAIT   = 0,
  parameter int unsigned RSP_DEPTH  = 2
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    obi_req_i,
  output logic                    obi_gnt_o,
  input  logic [ADDR_WIDTH-1:0]   obi_addr_i,
  input  logic                    obi_we_i,
  input  logic [DATA_WIDTH/8-1:0] obi_be_i,
  input  logic [DATA_WIDTH-1:0]   obi_wdata_i,
  output logic                    obi_rvalid_o,
  input  logic                    obi_rready_i,
  output logic [DATA_WIDTH-1:0]   obi_rdata_o,
  output logic                    obi_err_o
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(RSP_DEPTH + 1);
  localparam int unsigned BE_W  = DATA_WIDTH / 8;

  localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] SPAN = ADDR_WIDTH'(4 * DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] fifo_rdata [RSP_DEPTH];
  logic                  fifo_err [RSP_DEPTH];

  logic [3:0]            wcnt;
  logic [PTR_W-1:0]      wptr;
  logic [PTR_W-1:0]      rptr;
  logic [CNT_W-1:0]      count;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  accept;
  logic                  pop;
  logic                  addr_ok;
  logic [ADDR_WIDTH-1:0] offset;
  logic [IDX_W-1:0]      index;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign fifo_full  = (count == CNT_W'(RSP_DEPTH));
  assign fifo_empty = (count == '0);

  // Grant uses the registered full flag, so a pop only frees a slot from the next cycle on
  assign obi_gnt_o = !reset_i && obi_req_i && !fifo_full && (wcnt == 4'(GNT_WAIT));
  assign accept    = obi_req_i && obi_gnt_o;

  assign obi_rvalid_o = !reset_i && !fifo_empty;
  assign pop          = obi_rvalid_o && obi_rready_i;
  assign obi_rdata_o  = obi_rvalid_o ? fifo_rdata[rptr] : '0;
  assign obi_err_o    = obi_rvalid_o && fifo_err[rptr];

  assign offset  = obi_addr_i - BASE;
  assign addr_ok = (obi_addr_i >= BASE) && (offset < SPAN) && (obi_addr_i[1:0] == 2'b00);
  assign index   = offset[IDX_W+1:2];

  always_comb begin
    rsp_rdata = '0;
    rsp_err   = 1'b0;
    if (!addr_ok) begin
      rsp_err = 1'b1;
    end else if (!obi_we_i) begin
      rsp_rdata = mem[index];
    end
  end

  // Saturates at GNT_WAIT so a request stalled by a full FIFO is granted as soon as space frees
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wcnt <= '0;
    end else if (accept || !obi_req_i) begin
      wcnt <= '0;
    end else if (wcnt != 4'(GNT_WAIT)) begin
      wcnt <= wcnt + 4'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else if (accept && obi_we_i && addr_ok) begin
      for (int b = 0; b < int'(BE_W); b++) begin
        if (obi_be_i[b]) begin
          mem[index][8*b +: 8] <= obi_wdata_i[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      for (int i = 0; i < int'(RSP_DEPTH); i++) begin
        fifo_rdata[i] <= '0;
        fifo_err[i]   <= 1'b0;
      end
    end else begin
      if (accept) begin
        fifo_rdata[wptr] <= rsp_rdata;
        fifo_err[wptr]   <= rsp_err;
        wptr             <= ptr_next(wptr);
      end
      if (pop) begin
        rptr <= ptr_next(rptr);
      end
      if (accept && !pop) begin
        count <= count + 1'b1;
      end else if (!accept && pop) begin
        count <= count - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_obi_sbr_mem.sv
// Directed bench for obi_sbr_mem with one grant wait state and a two-entry response FIFO.
module tb_obi_sbr_mem;

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic        gnt;
  logic [31:0] addr;
  logic        we;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        rvalid;
  logic        rready;
  logic [31:0] rdata;
  logic        err;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  obi_sbr_mem #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .DEPTH     (16),
    .BASE_ADDR (32'h0000_0000),
    .GNT_WAIT  (1),
    .RSP_DEPTH (2)
  ) dut (
    .clk_i       (clk),
    .reset_i     (reset),
    .obi_req_i   (req),
    .obi_gnt_o   (gnt),
    .obi_addr_i  (addr),
    .obi_we_i    (we),
    .obi_be_i    (be),
    .obi_wdata_i (wdata),
    .obi_rvalid_o(rvalid),
    .obi_rready_i(rready),
    .obi_rdata_o (rdata),
    .obi_err_o   (err)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // One complete access from idle with rready held high: wait, grant, response, idle
  task automatic applyStimulus(input string tag, input logic w, input logic [31:0] a,
                               input logic [3:0] b, input logic [31:0] d,
                               input logic [31:0] exp_data, input logic exp_err);
    nextCycle();
    req = 1'b1; we = w; addr = a; be = b; wdata = d; rready = 1'b1;
    #1;
    checkOutput({tag, "_gnt_wait"}, 32'(gnt), 32'd0);
    nextCycle(); #1;
    checkOutput({tag, "_gnt"}, 32'(gnt), 32'd1);
    checkOutput({tag, "_rvalid_early"}, 32'(rvalid), 32'd0);
    nextCycle();
    req = 1'b0;
    #1;
    checkOutput({tag, "_rvalid"}, 32'(rvalid), 32'd1);
    checkOutput({tag, "_rdata"}, rdata, exp_data);
    checkOutput({tag, "_err"}, 32'(err), 32'(exp_err));
    nextCycle(); #1;
    checkOutput({tag, "_rvalid_done"}, 32'(rvalid), 32'd0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] simulation did not complete");
  end

  initial begin
    reset = 1'b1; req = 1'b1; addr = 32'h0; we = 1'b0; be = 4'h0; wdata = 32'h0; rready = 1'b1;

    // Reset held two cycles with a live request
    nextCycle(); #1;
    checkOutput("rst1_gnt", 32'(gnt), 32'd0);
    checkOutput("rst1_rvalid", 32'(rvalid), 32'd0);
    checkOutput("rst1_rdata", rdata, 32'h0);
    nextCycle(); #1;
    checkOutput("rst2_gnt", 32'(gnt), 32'd0);
    checkOutput("rst2_rvalid", 32'(rvalid), 32'd0);
    reset = 1'b0; req = 1'b0;

    applyStimulus("rd0_after_rst", 1'b0, 32'h00, 4'h0, 32'h0, 32'h0000_0000, 1'b0);

    applyStimulus("wr08_full", 1'b1, 32'h08, 4'hF, 32'hDEAD_BEEF, 32'h0, 1'b0);
    applyStimulus("rd08_full", 1'b0, 32'h08, 4'h0, 32'h0, 32'hDEAD_BEEF, 1'b0);
    applyStimulus("wr08_lane1", 1'b1, 32'h08, 4'b0010, 32'h0000_1200, 32'h0, 1'b0);
    applyStimulus("rd08_lane1", 1'b0, 32'h08, 4'h0, 32'h0, 32'hDEAD_12EF, 1'b0);

    applyStimulus("wr04", 1'b1, 32'h04, 4'hF, 32'h1122_3344, 32'h0, 1'b0);
    applyStimulus("wr0c", 1'b1, 32'h0C, 4'hF, 32'hCAFE_F00D, 32'h0, 1'b0);

    // Three back-to-back reads with the manager stalling the R channel
    nextCycle();
    rready = 1'b0; req = 1'b1; we = 1'b0; addr = 32'h08;
    #1;
    checkOutput("b2b_r1_wait", 32'(gnt), 32'd0);
    nextCycle(); #1;
    checkOutput("b2b_r1_gnt", 32'(gnt), 32'd1);
    nextCycle();
    addr = 32'h04;
    #1;
    checkOutput("b2b_r2_wait", 32'(gnt), 32'd0);
    checkOutput("b2b_head_r1", rdata, 32'hDEAD_12EF);
    nextCycle(); #1;
    checkOutput("b2b_r2_gnt", 32'(gnt), 32'd1);
    nextCycle();
    addr = 32'h0C;
    #1;
    checkOutput("b2b_r3_full_a", 32'(gnt), 32'd0);
    nextCycle(); #1;
    checkOutput("b2b_r3_full_b", 32'(gnt), 32'd0);
    checkOutput("b2b_head_stable_a", rdata, 32'hDEAD_12EF);
    nextCycle(); #1;
    checkOutput("b2b_r3_full_c", 32'(gnt), 32'd0);
    checkOutput("b2b_head_stable_b", rdata, 32'hDEAD_12EF);
    nextCycle();
    rready = 1'b1;
    #1;
    checkOutput("b2b_pop_cycle_gnt", 32'(gnt), 32'd0);
    checkOutput("b2b_pop1_rdata", rdata, 32'hDEAD_12EF);
    nextCycle(); #1;
    checkOutput("b2b_r3_gnt", 32'(gnt), 32'd1);
    checkOutput("b2b_pop2_rdata", rdata, 32'h1122_3344);
    nextCycle();
    req = 1'b0;
    #1;
    checkOutput("b2b_pop3_rvalid", 32'(rvalid), 32'd1);
    checkOutput("b2b_pop3_rdata", rdata, 32'hCAFE_F00D);
    nextCycle(); #1;
    checkOutput("b2b_drained", 32'(rvalid), 32'd0);

    // Out-of-range and misaligned accesses must error and leave memory intact
    applyStimulus("wr40_range", 1'b1, 32'h40, 4'hF, 32'hFFFF_FFFF, 32'h0, 1'b1);
    applyStimulus("rd40_range", 1'b0, 32'h40, 4'h0, 32'h0, 32'h0, 1'b1);
    applyStimulus("wr0a_misal", 1'b1, 32'h0A, 4'hF, 32'hFFFF_FFFF, 32'h0, 1'b1);
    applyStimulus("rd0a_misal", 1'b0, 32'h0A, 4'h0, 32'h0, 32'h0, 1'b1);
    applyStimulus("rd08_intact", 1'b0, 32'h08, 4'h0, 32'h0, 32'hDEAD_12EF, 1'b0);
    applyStimulus("rd00_intact", 1'b0, 32'h00, 4'h0, 32'h0, 32'h0000_0000, 1'b0);

    // Reset with two responses pending
    nextCycle();
    rready = 1'b0; req = 1'b1; we = 1'b0; addr = 32'h08;
    #1;
    checkOutput("rstp_r1_wait", 32'(gnt), 32'd0);
    nextCycle(); #1;
    checkOutput("rstp_r1_gnt", 32'(gnt), 32'd1);
    nextCycle();
    addr = 32'h04;
    #1;
    checkOutput("rstp_r2_wait", 32'(gnt), 32'd0);
    nextCycle(); #1;
    checkOutput("rstp_r2_gnt", 32'(gnt), 32'd1);
    checkOutput("rstp_pending", 32'(rvalid), 32'd1);
    nextCycle();
    req = 1'b0; reset = 1'b1;
    nextCycle();
    reset = 1'b0; rready = 1'b1;
    #1;
    checkOutput("rstp_rvalid_a", 32'(rvalid), 32'd0);
    checkOutput("rstp_rdata_a", rdata, 32'h0);
    nextCycle(); #1;
    checkOutput("rstp_rvalid_b", 32'(rvalid), 32'd0);
    applyStimulus("rd08_cleared", 1'b0, 32'h08, 4'h0, 32'h0, 32'h0000_0000, 1'b0);
    applyStimulus("rd0c_cleared", 1'b0, 32'h0C, 4'h0, 32'h0, 32'h0000_0000, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
